dmem_mmio: RTL and testbench

Data-side memory responder for the single-cycle RISC-V core. It answers the core's `MemWrite`/`Mem_WrAddr`/`Mem_WrData`/`ReadData` port with:
- word-addressed data RAM;
- memory-mapped 8N1 UART transmitter with a small byte FIFO;
- free-running 32-bit cycle counter.

Reads are combinational so the core completes loads in its single cycle. Writes and all internal state update on the rising clock edge.

---
 rtl/dmem_mmio.sv | 181 ++++++++++++++++++
 tb/tb_dmem_mmio.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory responder for a single-cycle RISC-V core.
//   Word RAM at 0x0000_0000 .. DEPTH_WORDS*4-1 (not cleared by reset)
//   0x1000 UART_DATA   : write pushes byte into TX FIFO, read returns 0
//   0x1004 UART_STATUS : read {overflow, fifo_full, fifo_empty, tx_active};
//                        write with bit3 set clears overflow
//   0x1008 CYCLE       : free-running counter, writable
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   MemWrite       - write strobe, sampled at rising edge
//   Mem_WrAddr     - byte address for read and write (bits [1:0] ignored)
//   Mem_WrData     - write data
//   ReadData       - combinational read data for Mem_WrAddr
//   uart_tx        - registered 8N1 serial output, idles high
//   tx_active      - transmit FSM not in IDLE
// The transmit FSM state is held in the typed signal 'state' for probing.
module dmem_mmio #(
  parameter int DEPTH_WORDS  = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        tx_active
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES  = 32'(DEPTH_WORDS * 4);
  localparam logic [FW:0] FIFO_CAP   = (FW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Address decode. OR-ing in the low two bits makes the register decode
  // ignore byte offsets while still matching the full upper address.
  logic [31:0] addr_hi;
  logic        ram_sel, data_sel, status_sel, cycle_sel;
  logic [AW-1:0] ram_idx;

  assign addr_hi    = Mem_WrAddr | 32'h3;
  assign ram_sel    = Mem_WrAddr < RAM_BYTES;
  assign data_sel   = addr_hi == 32'h0000_1003;
  assign status_sel = addr_hi == 32'h0000_1007;
  assign cycle_sel  = addr_hi == 32'h0000_100B;
  assign ram_idx    = Mem_WrAddr[AW+1:2];

  logic [31:0] ram [DEPTH_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic          fifo_full, fifo_empty, overflow;
  logic [31:0]   cycle;

  tx_state_t     state, state_next;
  logic [CW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          pop, push, tx_next;

  assign fifo_full  = count == FIFO_CAP;
  assign fifo_empty = count == '0;
  assign tx_active  = state != IDLE;
  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // does not rescue a push into a full FIFO.
  assign push = MemWrite && data_sel && !fifo_full;

  // Transmit FSM next-state logic.
  always_comb begin
    state_next = state;
    baud_next  = baud + CW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // uart_tx is registered from the next state so the line changes on
    // the same edge the FSM enters a state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycle    <= '0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      uart_tx <= tx_next;

      if (push) wr_ptr <= wr_ptr + FW'(1);
      if (pop)  rd_ptr <= rd_ptr + FW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FW + 1)'(1);
        2'b01:   count <= count - (FW + 1)'(1);
        default: count <= count;
      endcase

      if (MemWrite && data_sel && fifo_full)
        overflow <= 1'b1;
      else if (MemWrite && status_sel && Mem_WrData[3])
        overflow <= 1'b0;

      if (MemWrite && cycle_sel) cycle <= Mem_WrData;
      else                       cycle <= cycle + 32'd1;
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) ram[ram_idx] <= Mem_WrData;
    if (push) fifo_mem[wr_ptr] <= Mem_WrData[7:0];
  end

  always_comb begin
    ReadData = '0;
    if (ram_sel)
      ReadData = ram[ram_idx];
    else if (status_sel)
      ReadData = {28'b0, overflow, fifo_full, fifo_empty, tx_active};
    else if (cycle_sel)
      ReadData = cycle;
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio with a frame-level model.
// The model keeps the UART line as a queue of per-cycle levels (one whole
// frame appended when a byte is taken), a byte queue for the FIFO, and
// plain arrays/integers for RAM and the cycle counter.
module tb_dmem_mmio;

  localparam int DEPTH_WORDS  = 64;
  localparam int FIFO_DEPTH   = 4;
  localparam int CLKS_PER_BIT = 16;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        tx_active;

  dmem_mmio #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData),
    .ReadData  (ReadData),
    .uart_tx   (uart_tx),
    .tx_active (tx_active)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit          armed = 1'b0;
  int unsigned m_cycle;
  bit          m_ovf;
  logic [7:0]  m_fifo[$];
  bit          m_wave[$];
  logic [7:0]  m_sent[$];
  logic [31:0] m_ram[DEPTH_WORDS];
  bit          m_ram_ok[DEPTH_WORDS];

  function automatic bit m_read(input logic [31:0] addr, output logic [31:0] v);
    logic [31:0] a;
    a = addr & ~32'h3;
    v = '0;
    if (a < RAM_BYTES) begin
      v = m_ram[a / 4];
      return m_ram_ok[a / 4];
    end
    if (a == 32'h1004)
      v = {28'b0, m_ovf, m_fifo.size() == FIFO_DEPTH, m_fifo.size() == 0, m_wave.size() != 0};
    else if (a == 32'h1008)
      v = m_cycle;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [31:0] a;
    logic [7:0]  b;
    bit          full_pre;
    bit          take;
    bit          lvl;
    if (reset) begin
      armed   = 1'b1;
      m_cycle = 0;
      m_ovf   = 1'b0;
      m_fifo.delete();
      m_wave.delete();
    end else begin
      a        = Mem_WrAddr & ~32'h3;
      full_pre = m_fifo.size() == FIFO_DEPTH;
      // A byte is taken when the line is idle or on its last stop cycle.
      take     = (m_wave.size() <= 1) && (m_fifo.size() != 0);
      if (m_wave.size() != 0) void'(m_wave.pop_front());
      if (take) begin
        b = m_fifo.pop_front();
        m_sent.push_back(b);
        for (int i = 0; i < 10; i++) begin
          lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
          for (int j = 0; j < CLKS_PER_BIT; j++) m_wave.push_back(lvl);
        end
      end
      if (MemWrite) begin
        if (a < RAM_BYTES) begin
          m_ram[a / 4]    = Mem_WrData;
          m_ram_ok[a / 4] = 1'b1;
        end else if (a == 32'h1000) begin
          if (full_pre) m_ovf = 1'b1;
          else          m_fifo.push_back(Mem_WrData[7:0]);
        end else if (a == 32'h1004) begin
          if (Mem_WrData[3]) m_ovf = 1'b0;
        end
      end
      if (MemWrite && a == 32'h1008) m_cycle = Mem_WrData;
      else                           m_cycle = m_cycle + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] cmp_v;
  always @(negedge clk) begin
    if (armed) begin
      check("uart_tx", {31'b0, uart_tx}, {31'b0, (m_wave.size() != 0) ? m_wave[0] : 1'b1});
      check("tx_active", {31'b0, tx_active}, {31'b0, m_wave.size() != 0});
      if (m_read(Mem_WrAddr, cmp_v)) check("read_data", ReadData, cmp_v);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite   = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_bus(1'b1, a, d);
    tick();
    set_bus(1'b0, a, 32'h0);
  endtask

  // Present a read address, check the combinational data, use one cycle.
  task automatic peek(input logic [31:0] a, input logic [31:0] e, input string nm);
    Mem_WrAddr = a;
    #1;
    check(nm, ReadData, e);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [9:0] frame;
  int         active_cnt;
  int         sent_base;
  int         bad_cnt;

  initial begin
    reset = 1'b1;
    set_bus(1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_tx_active", {31'b0, tx_active}, 32'd0);
    peek(32'h1008, 32'h0, "reset_cycle");
    peek(32'h1004, 32'h2, "reset_status");

    // RAM and boundaries
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h00, 32'h1234_5678);
    wr(32'hFC, 32'hCAFE_F00D);
    peek(32'h10, 32'hDEAD_BEEF, "ram_read");
    peek(32'h13, 32'hDEAD_BEEF, "ram_read_offset");
    peek(32'h2000, 32'h0, "unmapped_2000");
    peek(32'hFC, 32'hCAFE_F00D, "ram_top_word");
    peek(32'h100, 32'h0, "ram_end_plus_one");

    // Unmapped / read-only
    wr(32'h100C, 32'hFFFF_FFFF);
    wr(32'h100, 32'hFFFF_FFFF);
    peek(32'h100C, 32'h0, "unmapped_100c");
    peek(32'h100, 32'h0, "unmapped_100");
    peek(32'h1004, 32'h2, "status_after_unmapped");
    peek(32'h1000, 32'h0, "uart_data_read");
    peek(32'h00, 32'h1234_5678, "ram0_untouched");
    peek(32'hFC, 32'hCAFE_F00D, "ramtop_untouched");

    // Cycle counter wrap
    wr(32'h1008, 32'hFFFF_FFFE);
    peek(32'h1008, 32'hFFFF_FFFE, "cycle_load");
    peek(32'h1008, 32'hFFFF_FFFF, "cycle_max");
    peek(32'h1008, 32'h0000_0000, "cycle_wrap");

    // Single byte 0xA5: start bit from E1, 10 bits of 16 cycles each
    wr(32'h1000, 32'hA5);
    peek(32'h1004, 32'h0, "status_after_push");
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * CLKS_PER_BIT; k++) begin
      if ((k % CLKS_PER_BIT) == 0 || (k % CLKS_PER_BIT) == 8 || (k % CLKS_PER_BIT) == 15)
        check("a5_line", {31'b0, uart_tx}, {31'b0, frame[k / CLKS_PER_BIT]});
      if (k == 0 || k == 10 * CLKS_PER_BIT - 1)
        check("a5_active", {31'b0, tx_active}, 32'd1);
      tick();
    end
    check("a5_done_active", {31'b0, tx_active}, 32'd0);
    peek(32'h1004, 32'h2, "a5_done_status");

    // Overflow: six writes, the sixth is dropped, five frames back-to-back
    sent_base  = m_sent.size();
    active_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      wr(32'h1000, 32'(i));
      if (tx_active) active_cnt++;
    end
    peek(32'h1004, 32'hD, "ovf_status");
    for (int n = 0; n < 900; n++) begin
      if (tx_active) active_cnt++;
      tick();
    end
    check("ovf_active_cycles", 32'(active_cnt), 32'd800);
    check("ovf_frames", 32'(m_sent.size() - sent_base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (sent_base + i < m_sent.size())
        check("ovf_frame_byte", {24'b0, m_sent[sent_base + i]}, 32'(i + 1));
    peek(32'h1004, 32'hA, "ovf_sticky_idle");
    wr(32'h1004, 32'h8);
    peek(32'h1004, 32'h2, "ovf_cleared");

    // Reset during DATA bit 3 with two bytes still queued
    wr(32'h1000, 32'h11);
    wr(32'h1000, 32'h22);
    wr(32'h1000, 32'h33);
    repeat (68) tick();
    check("mid_bit3_line", {31'b0, uart_tx}, 32'd0);
    peek(32'h1004, 32'h1, "mid_status");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_tx_active", {31'b0, tx_active}, 32'd0);
    peek(32'h1008, 32'h0, "rst_cycle");
    peek(32'h1004, 32'h2, "rst_status");
    bad_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      if (!uart_tx || tx_active) bad_cnt++;
      tick();
    end
    check("rst_no_frames", 32'(bad_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
